// File: rtl/fpga_led_pkg.sv
// Shared constants and divider sizing helpers for the LED bring-up block.
`timescale 1ns/1ps
package fpga_led_pkg;

    localparam int DEF_CLK_FREQ     = 50_000_000;
    localparam int DEF_CLK_AUX_FREQ = 27_000_000;
    localparam int DEF_BLINK_HZ     = 1;

    function automatic int half_cycles(input int freq, input int hz);
        return freq / (2 * hz);
    endfunction

    function automatic int cnt_width(input int half);
        return (half < 2) ? 1 : $clog2(half);
    endfunction

endpackage

// File: rtl/blink_div.sv
// Square-wave divider: counts 0..HALF-1 and toggles led at each wrap.
`timescale 1ns/1ps
module blink_div
    import fpga_led_pkg::*;
#(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst,
    output logic led
);

    localparam int W = cnt_width(HALF);
    localparam logic [W-1:0] LAST = W'(HALF - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            led <= 1'b0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            led <= ~led;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fpga_led_top.sv
// Board bring-up: switch mirrors, reset indicator and two 1 Hz blinkers.
// Optional FPGA_SW_SYNC_EN registers the switch paths through 2-flop synchronizers.
`timescale 1ns/1ps
module fpga_led_top
    import fpga_led_pkg::*;
#(
    parameter int CLK_FREQ     = DEF_CLK_FREQ,
    parameter int CLK_AUX_FREQ = DEF_CLK_AUX_FREQ,
    parameter int BLINK_HZ     = DEF_BLINK_HZ
) (
    input  logic fpga_CLK,
    input  logic fpga_RST,
    input  logic fpga_CLK_AUX,
    input  logic fpga_SW0,
    input  logic fpga_SW1,
    output logic fpga_LEDR0,
    output logic fpga_LEDR1,
    output logic fpga_LEDR2,
    output logic fpga_LEDR3,
    output logic fpga_SEL_CLK_AUX
);

    localparam int H1 = half_cycles(CLK_FREQ, BLINK_HZ);
    localparam int H2 = half_cycles(CLK_AUX_FREQ, BLINK_HZ);

    always_ff @(posedge fpga_CLK) begin
        fpga_LEDR3 <= ~fpga_RST;
    end

`ifdef FPGA_SW_SYNC_EN
    logic [1:0] sw0_sync;
    logic [1:0] sw1_sync;

    always_ff @(posedge fpga_CLK) begin
        if (fpga_RST) begin
            sw0_sync <= '0;
            sw1_sync <= '0;
        end else begin
            sw0_sync <= {sw0_sync[0], fpga_SW0};
            sw1_sync <= {sw1_sync[0], fpga_SW1};
        end
    end

    assign fpga_LEDR0       = sw0_sync[1];
    assign fpga_SEL_CLK_AUX = sw1_sync[1];
`else
    assign fpga_LEDR0       = fpga_SW0;
    assign fpga_SEL_CLK_AUX = fpga_SW1;
`endif

    // Only crossing between domains: reset into the aux clock.
    logic rst_aux_meta;
    logic rst_aux;

    always_ff @(posedge fpga_CLK_AUX) begin
        rst_aux_meta <= fpga_RST;
        rst_aux      <= rst_aux_meta;
    end

    blink_div #(.HALF(H1)) u_div_main (
        .clk (fpga_CLK),
        .rst (fpga_RST),
        .led (fpga_LEDR1)
    );

    blink_div #(.HALF(H2)) u_div_aux (
        .clk (fpga_CLK_AUX),
        .rst (rst_aux),
        .led (fpga_LEDR2)
    );

endmodule

// File: tb/tb_fpga_led_top.sv
// Self-checking bench for fpga_led_top with scaled-down frequencies (H1=50, H2=27).
`timescale 1ns/1ps
module tb_fpga_led_top;

    logic clk = 1'b0;
    logic aux_clk = 1'b0;
    logic rst = 1'b1;
    logic sw0 = 1'b0;
    logic sw1 = 1'b0;
    logic aux_force = 1'b1;
    logic led0, led1, led2, led3, sel_aux;

    int total = 0;
    int bad = 0;

    longint exp1[$];
    longint exp2[$];
    bit mon1_en = 1'b0;
    bit mon2_en = 1'b0;
    longint t1_last = -1;
    longint t2_last = -1;

    fpga_led_top #(
        .CLK_FREQ     (100),
        .CLK_AUX_FREQ (54),
        .BLINK_HZ     (1)
    ) dut (
        .fpga_CLK         (clk),
        .fpga_RST         (rst),
        .fpga_CLK_AUX     (aux_clk),
        .fpga_SW0         (sw0),
        .fpga_SW1         (sw1),
        .fpga_LEDR0       (led0),
        .fpga_LEDR1       (led1),
        .fpga_LEDR2       (led2),
        .fpga_LEDR3       (led3),
        .fpga_SEL_CLK_AUX (sel_aux)
    );

    always #10 clk = ~clk;
    // Aux oscillator runs only while enabled (or forced during power-up reset).
    always #18 aux_clk = (sel_aux | aux_force) ? ~aux_clk : 1'b0;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(posedge led1) begin
        if (mon1_en) begin
            if (t1_last >= 0 && exp1.size() > 0) chk("led1_period", $time - t1_last, exp1.pop_front());
            t1_last = $time;
        end
    end

    always @(posedge led2) begin
        if (mon2_en) begin
            if (t2_last >= 0 && exp2.size() > 0) chk("led2_period", $time - t2_last, exp2.pop_front());
            t2_last = $time;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Power-up reset: aux clock runs briefly so its domain is cleared.
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("rst_led3", led3, 0);
            if (i == 9) chk("rst_led1", led1, 0);
        end
        aux_force = 1'b0;
        step(2);
        rst = 1'b0;
        mon1_en = 1'b1;
        step(1);
        chk("rel_led3", led3, 1);
        step(48);
        chk("led1_pre49", led1, 0);
        step(1);
        chk("led1_at50", led1, 1);

        exp1.push_back(2000);
        exp1.push_back(2000);
        for (int i = 0; i < 400 && exp1.size() != 0; i++) step(1);
        chk("led1_pending", exp1.size(), 0);
        mon1_en = 1'b0;

        chk("led2_idle_a", led2, 0);
        chk("sel_idle", sel_aux, 0);

        // SW0 path
        sw0 = 1'b1;
`ifdef FPGA_SW_SYNC_EN
        step(1);
        chk("sw0_rise_lat1", led0, 0);
        step(1);
        chk("sw0_rise_lat2", led0, 1);
        sw0 = 1'b0;
        step(1);
        chk("sw0_fall_lat1", led0, 1);
        step(1);
        chk("sw0_fall_lat2", led0, 0);
`else
        #1;
        chk("sw0_rise", led0, 1);
        step(1);
        sw0 = 1'b0;
        #1;
        chk("sw0_fall", led0, 0);
        step(1);
`endif
        step(20);
        chk("led2_idle_b", led2, 0);

        // SW1 starts aux oscillator; LEDR2 period in aux cycles
        mon2_en = 1'b1;
        exp2.push_back(1944);
        exp2.push_back(1944);
        sw1 = 1'b1;
`ifdef FPGA_SW_SYNC_EN
        step(1);
        chk("sel_lat1", sel_aux, 0);
        step(1);
        chk("sel_lat2", sel_aux, 1);
`else
        #1;
        chk("sel_on", sel_aux, 1);
`endif
        for (int i = 0; i < 600 && exp2.size() != 0; i++) step(1);
        chk("led2_pending", exp2.size(), 0);
        mon2_en = 1'b0;

        // Mid-operation reset pulse
        step(17);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("mid_led3", led3, 0);
            chk("mid_led1", led1, 0);
        end
        rst = 1'b0;
        step(1);
        chk("mid_rel_led3", led3, 1);
        chk("mid_rel_led1", led1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpga_led_top.md
Name: fpga_led_top

Overview:
- Top-level board-bring-up block: drives four LEDs and an auxiliary-clock select from two switches, the main 50 MHz clock and a 27 MHz auxiliary clock.
- LEDR0 mirrors SW0; LEDR3 shows "out of reset"; LEDR1 and LEDR2 blink at 1 Hz from the main and auxiliary clocks respectively.
- SW1 enables the external auxiliary-clock source through fpga_SEL_CLK_AUX.

Parameters:
- CLK_FREQ, 50_000_000: fpga_CLK frequency in Hz.
- CLK_AUX_FREQ, 27_000_000: fpga_CLK_AUX frequency in Hz.
- BLINK_HZ, 1: blink frequency of LEDR1 and LEDR2 in Hz. CLK_FREQ/(2*BLINK_HZ) and CLK_AUX_FREQ/(2*BLINK_HZ) must both be integers ≥ 2.

Ports:
- fpga_CLK  in  1  main clock, 50 MHz; all logic except the LEDR2 path runs on it.
- fpga_RST  in  1  synchronous reset, active-high, sampled on the fpga_CLK rising edge.
- fpga_CLK_AUX  in  1  auxiliary clock, 27 MHz; may be stopped while fpga_SEL_CLK_AUX=0.
- fpga_SW0  in  1  switch 0.
- fpga_SW1  in  1  switch 1, auxiliary-clock enable.
- fpga_LEDR0  out  1  copy of SW0.
- fpga_LEDR1  out  1  1 Hz blink, fpga_CLK domain.
- fpga_LEDR2  out  1  1 Hz blink, fpga_CLK_AUX domain.
- fpga_LEDR3  out  1  1 = out of reset.
- fpga_SEL_CLK_AUX  out  1  auxiliary-clock oscillator enable.

Behaviour:
- Reset values: fpga_LEDR1=0, fpga_LEDR3=0, fpga_LEDR2=0. The fpga_CLK-domain divider counter clears to 0.
- fpga_LEDR3
  - Register in the fpga_CLK domain.
  - Goes to 0 on the first fpga_CLK edge where fpga_RST=1.
  - Goes to 1 on the first fpga_CLK edge where fpga_RST=0 (one-cycle latency).
  - Reasserting reset mid-operation returns it to 0 on the next edge.
- fpga_LEDR0 = fpga_SW0, combinational; not affected by reset.
- fpga_SEL_CLK_AUX = fpga_SW1, combinational; not affected by reset.
- fpga_LEDR1 divider
  - Counter 0..H1-1, with H1 = CLK_FREQ/(2*BLINK_HZ); width = $clog2(H1).
  - At count H1-1: the counter wraps to 0 and fpga_LEDR1 toggles.
  - Output period = 2*H1 fpga_CLK cycles, i.e. 1.000 s at the defaults.
  - Reset mid-count clears both the counter and the LED.
- fpga_LEDR2 divider
  - Same structure on fpga_CLK_AUX, with H2 = CLK_AUX_FREQ/(2*BLINK_HZ) = 13_500_000 at the defaults.
  - Its reset is fpga_RST passed through a 2-flop synchronizer clocked by fpga_CLK_AUX. The counter and LED clear while the synchronized reset is high.
  - If fpga_CLK_AUX stops, the counter and LED hold their values. Counting resumes from the held value when the clock restarts.
- Clock domains: no other signal crosses between the two clock domains.

Optional Feature:
- Macro: FPGA_SW_SYNC_EN.
- When defined:
  - fpga_SW0 and fpga_SW1 each pass through a 2-flop synchronizer clocked by fpga_CLK before reaching fpga_LEDR0 and fpga_SEL_CLK_AUX.
  - Latency is 2 fpga_CLK edges.
  - The synchronizer flops reset to 0.
- When undefined: both paths are combinational with zero latency, as specified above.

Decomposition:
- Package fpga_led_pkg holds:
  - default frequency constants (50_000_000, 27_000_000, 1);
  - a function computing the half-period cycle count;
  - a function computing the counter width.
- Sub-module blink_div (parameter HALF), instantiated twice, once per clock domain.
  - Ports: clk, rst, led.
  - Contents: counter, wrap logic and toggle flop.
- The reset synchronizer for the aux domain is written inline in fpga_led_top.

Test Plan:
Benches use CLK_FREQ=100, CLK_AUX_FREQ=54 and BLINK_HZ=1 (H1=50, H2=27), with a 20 ns fpga_CLK and a 36 ns fpga_CLK_AUX.
- Reset: hold fpga_RST=1 for 10 cycles, then release → LEDR3=0 throughout reset, LEDR3=1 one edge after release, LEDR1=0 until 50 cycles after release.
- Mid-operation reset: pulse fpga_RST high for 5 cycles → LEDR3=0 and LEDR1=0 during the pulse; LEDR3 returns to 1 one edge after release.
- SW0: set 1, then 0 → LEDR0 follows immediately, or after 2 edges with FPGA_SW_SYNC_EN.
- SW1: set 1 → SEL_CLK_AUX=1 and the aux clock starts. With SW1=0, LEDR2 holds at 0 while the aux clock is idle.
- LEDR1 period: measure between two rising edges → exactly 100 fpga_CLK cycles (2000 ns). Default-parameter run → 1 s ±10%.
- LEDR2 period: with SW1=1 → exactly 54 fpga_CLK_AUX cycles (1944 ns). Default-parameter run → 1 s ±10%.
